cc_enc: RTL and testbench

Tail-terminated K=7 convolutional encoder with puncturing, the stage directly downstream of the Reed-Solomon encoder in the OFDM transmit chain. It accepts RS-coded bytes MSB first, appends the 0x00 tail byte at the end of each burst, encodes with generators 171/133 (octal), and punctures to the selected rate. It emits one coded bit per accepted output handshake toward the interleaver.

---
 rtl/cc_enc.sv | 236 +++++++++++++++++++++++
 tb/tb_cc_enc.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cc_enc.sv
// K=7 (171/133) tail-terminated convolutional encoder with puncturing.
// Define CC_PUNCTURE_EN for rates 2/3, 3/4, 5/6; otherwise fixed rate 1/2.
module cc_enc #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] in_bits,
    input  logic         in_valid,
    input  logic         in_last,
    output logic         in_ready,
    input  logic [1:0]   rate_sel,
    output logic         out_bit,
    output logic         out_valid,
    output logic         out_last,
    input  logic         out_ready
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        TAIL
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [W-1:0]  hold_data;
    logic          hold_full;
    logic          hold_last;

    logic [W-1:0]  sh_data;
    logic [CW-1:0] sh_cnt;
    logic          sh_valid;
    logic          sh_last;

    logic [5:0]    enc_s;
    logic [2:0]    phase;
    logic [2:0]    phase_max;
    logic          sub;
    logic          last_pend;

    logic          u;
    logic          x_bit;
    logic          y_bit;
    logic          sel_y;
    logic          coded;
    logic          vld;
    logic          bit_final;
    logic          cnt_end;
    logic          fire_in;
    logic          fire_out;
    logic          bit_done;
    logic          byte_done;
    logic          direct;
    logic          to_hold;
    logic          move_hold;

    assign in_ready  = ~hold_full & ~last_pend;
    assign fire_in   = in_valid & in_ready;

    assign u     = sh_data[W-1];
    assign x_bit = u ^ enc_s[0] ^ enc_s[1] ^ enc_s[2] ^ enc_s[5];
    assign y_bit = u ^ enc_s[1] ^ enc_s[2] ^ enc_s[4] ^ enc_s[5];

    // Phase 0 sends X then Y; later phases send one bit: odd -> Y, even -> X.
    assign sel_y     = (phase == 3'd0) ? sub : phase[0];
    assign coded     = sel_y ? y_bit : x_bit;
    assign bit_final = (phase != 3'd0) | sub;
    assign cnt_end   = (sh_cnt == CNT_MAX);

    assign vld       = (state == TAIL) | ((state == DATA) & sh_valid);
    assign fire_out  = vld & out_ready;
    assign bit_done  = fire_out & bit_final;
    assign byte_done = bit_done & cnt_end;

    // A new byte bypasses the holding register when the shifter frees up.
    assign direct    = fire_in & ((state == IDLE) |
                       ((state == DATA) & (~sh_valid | byte_done)));
    assign to_hold   = fire_in & ~direct;
    assign move_hold = (state == DATA) & hold_full &
                       (~sh_valid | (byte_done & ~sh_last));

`ifdef CC_PUNCTURE_EN
    logic [1:0] rate_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rate_q <= 2'd0;
        end else if ((state == IDLE) && fire_in) begin
            rate_q <= rate_sel;
        end
    end

    always_comb begin
        phase_max = 3'd0;
        unique case (rate_q)
            2'd0: phase_max = 3'd0;
            2'd1: phase_max = 3'd1;
            2'd2: phase_max = 3'd2;
            2'd3: phase_max = 3'd4;
            default: phase_max = 3'd0;
        endcase
    end
`else
    logic unused_rate;

    assign phase_max   = 3'd0;
    assign unused_rate = ^rate_sel;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        out_valid = 1'b0;
        out_bit   = 1'b0;
        out_last  = 1'b0;
        unique case (state)
            IDLE: begin
                if (fire_in) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                out_valid = sh_valid;
                out_bit   = sh_valid & coded;
                if (byte_done && sh_last) begin
                    state_nxt = TAIL;
                end
            end
            TAIL: begin
                out_valid = 1'b1;
                out_bit   = coded;
                out_last  = bit_final & cnt_end;
                if (byte_done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_data <= '0;
            hold_full <= 1'b0;
            hold_last <= 1'b0;
        end else if (move_hold) begin
            hold_full <= 1'b0;
        end else if (to_hold) begin
            hold_data <= in_bits;
            hold_last <= in_last;
            hold_full <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh_data   <= '0;
            sh_cnt    <= '0;
            sh_valid  <= 1'b0;
            sh_last   <= 1'b0;
            enc_s     <= '0;
            phase     <= 3'd0;
            sub       <= 1'b0;
            last_pend <= 1'b0;
        end else if (state == IDLE) begin
            if (fire_in) begin
                enc_s     <= '0;
                phase     <= 3'd0;
                sub       <= 1'b0;
                sh_data   <= in_bits;
                sh_cnt    <= '0;
                sh_valid  <= 1'b1;
                sh_last   <= in_last;
                last_pend <= in_last;
            end
        end else begin
            if (fire_out) begin
                sub <= (phase == 3'd0) & ~sub;
                if (bit_final) begin
                    enc_s   <= {enc_s[4:0], u};
                    phase   <= (phase == phase_max) ? 3'd0 : phase + 3'd1;
                    sh_data <= sh_data << 1;
                    sh_cnt  <= sh_cnt + CW'(1);
                end
            end
            if (byte_done) begin
                sh_cnt <= '0;
                if (state == TAIL) begin
                    enc_s     <= '0;
                    phase     <= 3'd0;
                    sub       <= 1'b0;
                    sh_valid  <= 1'b0;
                    sh_last   <= 1'b0;
                    last_pend <= 1'b0;
                end else if (sh_last) begin
                    sh_data <= '0;
                    sh_last <= 1'b0;
                end else if (hold_full) begin
                    sh_data <= hold_data;
                    sh_last <= hold_last;
                end else if (fire_in) begin
                    sh_data <= in_bits;
                    sh_last <= in_last;
                end else begin
                    sh_valid <= 1'b0;
                end
            end else if (!sh_valid) begin
                if (hold_full) begin
                    sh_data  <= hold_data;
                    sh_last  <= hold_last;
                    sh_valid <= 1'b1;
                end else if (fire_in) begin
                    sh_data  <= in_bits;
                    sh_last  <= in_last;
                    sh_valid <= 1'b1;
                end
            end
            if (fire_in && in_last) begin
                last_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cc_enc.sv
// Scoreboard bench for cc_enc: reference encoder/puncturer feeds an
// expected-bit queue that is drained as output handshakes occur.
module tb_cc_enc;

    typedef struct packed {
        logic b;
        logic l;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_bits;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic [1:0] rate_sel;
    logic       out_bit;
    logic       out_valid;
    logic       out_last;
    logic       out_ready;

    exp_t       sb[$];
    logic [7:0] bq[$];
    int         n_chk;
    int         n_pass;
    int         cnt;
    int         last_len;
    bit         bp;
    bit         stall_v;
    logic [1:0] stall_val;
    bit         lp;

    cc_enc #(.W(8)) dut (
        .clk      (clk),
        .reset    (rst_n),
        .in_bits  (in_bits),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_ready (in_ready),
        .rate_sel (rate_sel),
        .out_bit  (out_bit),
        .out_valid(out_valid),
        .out_last (out_last),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int eff(input int r);
`ifdef CC_PUNCTURE_EN
        return r;
`else
        return 0 * r;
`endif
    endfunction

    task automatic model(input int rate);
        exp_t       tmp[$];
        exp_t       e;
        logic [5:0] st;
        logic [6:0] r;
        logic [9:0] mask;
        int         per;
        int         nb;
        int         k;
        logic       ub;
        st = '0;
        case (rate)
            0:       begin per = 1; mask = 10'b0000000011; end
            1:       begin per = 2; mask = 10'b0000001011; end
            2:       begin per = 3; mask = 10'b0000011011; end
            default: begin per = 5; mask = 10'b0110011011; end
        endcase
        nb = 8 * (bq.size() + 1);
        for (int i = 0; i < nb; i++) begin
            if (i < 8 * bq.size()) ub = bq[i / 8][7 - (i % 8)];
            else ub = 1'b0;
            r = {ub, st};
            k = i % per;
            if (mask[2 * k]) begin
                e.b = ^(r & 7'o171);
                e.l = 1'b0;
                tmp.push_back(e);
            end
            if (mask[2 * k + 1]) begin
                e.b = ^(r & 7'o133);
                e.l = 1'b0;
                tmp.push_back(e);
            end
            st = {ub, st[5:1]};
        end
        tmp[tmp.size() - 1].l = 1'b1;
        foreach (tmp[i]) sb.push_back(tmp[i]);
    endtask

    task automatic push_imp();
        logic [31:0] v;
        exp_t        e;
        v = 32'hEF1C0000;
        for (int i = 0; i < 32; i++) begin
            e.b = v[31 - i];
            e.l = (i == 31);
            sb.push_back(e);
        end
    endtask

    task automatic drive_burst(input logic [1:0] rate, input bit hold);
        bit ok;
        for (int i = 0; i < bq.size(); i++) begin
            in_bits  = bq[i];
            in_last  = (i == bq.size() - 1);
            rate_sel = (i == 0) ? rate : 2'($urandom);
            in_valid = 1'b1;
            ok = 1'b0;
            for (int t = 0; t < 3000 && !ok; t++) begin
                @(negedge clk);
                ok = in_ready;
                @(posedge clk);
                #1;
            end
            check("in_accept", 32'(ok), 32'd1);
        end
        if (!hold) begin
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        while (sb.size() != 0 && t < 5000) begin
            @(posedge clk);
            t++;
        end
        check({tag, "_drain"}, 32'(sb.size()), 32'd0);
        @(negedge clk);
        check({tag, "_idle"}, 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = bp ? ($urandom_range(0, 9) < 3) : 1'b1;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            stall_v = 1'b0;
            lp      = 1'b0;
            cnt     = 0;
        end else begin
            if (stall_v) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_hold", 32'({out_bit, out_last}), 32'(stall_val));
            end
            stall_v   = out_valid & ~out_ready;
            stall_val = {out_bit, out_last};
            if (lp) check("in_ready_low", 32'(in_ready), 32'd0);
            if (in_valid && in_ready && in_last) lp = 1'b1;
            if (out_valid && out_ready) begin
                cnt++;
                check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("out_bit", 32'(out_bit), 32'(e.b));
                    check("out_last", 32'(out_last), 32'(e.l));
                end
                if (out_last) begin
                    last_len = cnt;
                    cnt      = 0;
                    lp       = 1'b0;
                end
            end
        end
    end

    initial begin
        int zlen[3];
        int t;
        n_chk    = 0;
        n_pass   = 0;
        last_len = 0;
        bp       = 1'b0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_bits  = 8'h00;
        in_last  = 1'b0;
        rate_sel = 2'd0;
`ifdef CC_PUNCTURE_EN
        zlen = '{48, 43, 39};
`else
        zlen = '{64, 64, 64};
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_bit", 32'(out_bit), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        check("post_rst_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

        bq = {8'h80};
        push_imp();
        drive_burst(2'd0, 1'b0);
        drain("imp");
        check("imp_len", 32'(last_len), 32'd32);

        for (int r = 1; r < 4; r++) begin
            bq = {8'h00, 8'h00, 8'h00};
            model(eff(r));
            drive_burst(2'(r), 1'b0);
            drain("zero");
            check("zero_len", 32'(last_len), 32'(zlen[r - 1]));
        end

        bq = {8'($urandom), 8'($urandom)};
        model(eff(2));
        drive_burst(2'd2, 1'b1);
        bq = {8'($urandom)};
        model(eff(1));
        drive_burst(2'd1, 1'b0);
        drain("b2b");
        check("b2b_len2", 32'(last_len), (eff(1) == 1) ? 32'd24 : 32'd32);

        bq = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
        model(eff(2));
        bp = 1'b1;
        drive_burst(2'd2, 1'b0);
        drain("bp");
        bp = 1'b0;
        check("bp_len", 32'(last_len), (eff(2) == 2) ? 32'd54 : 32'd80);

        bq = {8'h80};
        push_imp();
        drive_burst(2'd0, 1'b0);
        t = 0;
        while (cnt < 20 && t < 200) begin
            @(posedge clk);
            t++;
        end
        check("tail_reached", 32'(cnt >= 20), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_async_valid", 32'(out_valid), 32'd0);
        check("rst_async_last", 32'(out_last), 32'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
        @(negedge clk);
        check("rel_in_ready", 32'(in_ready), 32'd1);
        check("rel_no_tail", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        bq = {8'h80};
        push_imp();
        drive_burst(2'd0, 1'b0);
        drain("imp2");
        check("imp2_len", 32'(last_len), 32'd32);

        bq = {8'h80};
`ifdef CC_PUNCTURE_EN
        model(3);
`else
        push_imp();
`endif
        drive_burst(2'd3, 1'b0);
        drain("r3");
        check("r3_len", 32'(last_len), (eff(3) == 3) ? 32'd20 : 32'd32);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
